monitor_loader: RTL and testbench

//  Serial boot/monitor stage upstream of the cpu. Takes bytes from the UART receiver and executes

---
 rtl/robin_pkg.sv | 28 ++
 rtl/loader_timeout.sv | 28 ++
 rtl/monitor_loader.sv | 175 +++++++++++++++++
 tb/tb_monitor_loader.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robin_pkg.sv
// Shared constants for the serial monitor loader: host opcodes, reply bytes and FSM states.
package robin_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_EXEC = 8'h58;

  localparam logic [7:0] RSP_ERR  = 8'h3F;
  localparam logic [7:0] RSP_BUSY = 8'h21;

  typedef enum logic [3:0] {
    IDLE,
    ADDRH,
    ADDRL,
    LENH,
    LENL,
    WDATA,
    RADDR,
    RWAIT1,
    RWAIT2,
    RSEND,
    TXWAIT,
    HALTWAIT,
    START
  } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-gap watchdog: counts clocks since the last clear and holds expired once the limit is reached.
module loader_timeout #(
  parameter int unsigned limit = 12000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic expired
);

  localparam int unsigned width = $clog2(limit + 1);

  logic [width-1:0] count;

  assign expired = (count == width'(limit));

  // Saturates at the limit so a long idle period cannot wrap back to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/monitor_loader.sv
// Serial boot monitor: parses host commands from the UART, loads/reads the shared byte memory
// and controls cpu halt/reset/start address.
module monitor_loader
  import robin_pkg::*;
#(
  parameter int unsigned addr_width = 9,
  parameter int unsigned timeout    = 12000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out,
  output logic                  mem_owner,
  output logic [addr_width-1:0] start_address,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted
);

  loader_state_t         state;
  logic [7:0]            opcode;
  logic [7:0]            addr_hi;
  logic [addr_width-1:0] addr;
  logic [7:0]            len_hi;
  logic [15:0]           count;
  logic [7:0]            checksum;
  logic                  expired;
  logic                  receiving;
  logic [15:0]           len_full;

  assign receiving = state inside {ADDRH, ADDRL, LENH, LENL, WDATA};
  assign len_full  = {len_hi, rx_data};

  loader_timeout #(
    .limit(timeout)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (rx_valid),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      opcode        <= 8'h00;
      addr_hi       <= 8'h00;
      addr          <= '0;
      len_hi        <= 8'h00;
      count         <= 16'd0;
      checksum      <= 8'h00;
      tx_data       <= 8'h00;
      tx_start      <= 1'b0;
      mem_raddr     <= '0;
      mem_waddr     <= '0;
      mem_data_in   <= 8'h00;
      mem_write     <= 1'b0;
      mem_owner     <= 1'b1;
      start_address <= '0;
      cpu_reset     <= 1'b1;
      cpu_halt      <= 1'b1;
    end else begin
      tx_start  <= 1'b0;
      mem_write <= 1'b0;
      // Held from power-up until the first start; afterwards only the START pulse survives.
      cpu_reset <= cpu_reset & cpu_halt;
      if (receiving && expired && !rx_valid) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rx_valid) begin
            opcode <= rx_data;
            case (rx_data)
              CMD_LOAD, CMD_READ, CMD_EXEC: state <= ADDRH;
              CMD_HALT: begin
                cpu_halt <= 1'b1;
                state    <= HALTWAIT;
              end
              default: begin
                tx_data <= RSP_ERR;
                state   <= TXWAIT;
              end
            endcase
          end
          ADDRH: if (rx_valid) begin
            addr_hi <= rx_data;
            state   <= ADDRL;
          end
          ADDRL: if (rx_valid) begin
            addr  <= addr_width'({addr_hi, rx_data});
            state <= (opcode == CMD_EXEC) ? START : LENH;
          end
          LENH: if (rx_valid) begin
            len_hi <= rx_data;
            state  <= LENL;
          end
          LENL: if (rx_valid) begin
            count    <= len_full;
            checksum <= 8'h00;
            if (opcode == CMD_LOAD) begin
              if (len_full == 16'd0) begin
                tx_data <= mem_owner ? 8'h00 : RSP_BUSY;
                state   <= TXWAIT;
              end else begin
                state <= WDATA;
              end
            end else if (!mem_owner) begin
              tx_data <= RSP_BUSY;
              state   <= TXWAIT;
            end else if (len_full == 16'd0) begin
              state <= IDLE;
            end else begin
              state <= RADDR;
            end
          end
          // Without memory ownership the payload is still consumed so the host stays in sync.
          WDATA: if (rx_valid) begin
            if (mem_owner) begin
              mem_waddr   <= addr;
              mem_data_in <= rx_data;
              mem_write   <= 1'b1;
            end
            addr     <= addr + 1'b1;
            checksum <= checksum + rx_data;
            count    <= count - 1'b1;
            if (count == 16'd1) begin
              tx_data <= mem_owner ? (checksum + rx_data) : RSP_BUSY;
              state   <= TXWAIT;
            end
          end
          RADDR: begin
            mem_raddr <= addr;
            addr      <= addr + 1'b1;
            state     <= RWAIT1;
          end
          RWAIT1: state <= RWAIT2;
          RWAIT2: state <= RSEND;
          RSEND: if (!tx_busy) begin
            tx_data  <= mem_data_out;
            tx_start <= 1'b1;
            count    <= count - 1'b1;
            state    <= (count == 16'd1) ? IDLE : RADDR;
          end
          TXWAIT: if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= IDLE;
          end
          HALTWAIT: if (cpu_halted) begin
            mem_owner <= 1'b1;
            tx_data   <= CMD_HALT;
            state     <= TXWAIT;
          end
          START: begin
            start_address <= addr;
            cpu_reset     <= 1'b1;
            cpu_halt      <= 1'b0;
            mem_owner     <= 1'b0;
            tx_data       <= CMD_EXEC;
            state         <= TXWAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_loader.sv
// Self-checking bench for monitor_loader: scripted command scenarios plus randomized load/read traffic.
module tb_monitor_loader;

  localparam int AW    = 9;
  localparam int TMO   = 300;
  localparam int MSIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_data_in;
  logic          mem_write;
  logic [7:0]    mem_data_out;
  logic          mem_owner;
  logic [AW-1:0] start_address;
  logic          cpu_reset;
  logic          cpu_halt;
  logic          cpu_halted = 1'b1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  monitor_loader #(.addr_width(AW), .timeout(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out), .mem_owner(mem_owner),
    .start_address(start_address), .cpu_reset(cpu_reset), .cpu_halt(cpu_halt),
    .cpu_halted(cpu_halted)
  );

  // Memory with a two-stage read pipeline: address at cycle t, data usable at t+2.
  logic [7:0]    ram [MSIZE];
  logic [7:0]    ram_q1;
  logic          ram_fill = 1'b0;
  logic [AW-1:0] wr_a_q [$];
  logic [7:0]    wr_d_q [$];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < MSIZE; i++) ram[i] <= 8'((i * 37 + 11) & 255);
    end else if (mem_write) begin
      ram[mem_waddr] <= mem_data_in;
      wr_a_q.push_back(mem_waddr);
      wr_d_q.push_back(mem_data_in);
    end
    ram_q1       <= ram[mem_raddr];
    mem_data_out <= ram_q1;
  end

  // Transmitter: busy for busy_len clocks after each start, or while force_busy is set.
  int         busy_cnt = 0;
  int         busy_len = 2;
  logic       force_busy = 1'b0;
  int         tx_while_busy = 0;
  logic [7:0] tx_q [$];
  assign tx_busy = force_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) begin
      if (tx_busy) tx_while_busy <= tx_while_busy + 1;
      tx_q.push_back(tx_data);
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  int            rst_high = 0;
  int            rst_run = 0;
  int            raddr_changes = 0;
  logic [AW-1:0] raddr_prev = '0;
  always @(posedge clk) begin
    if (cpu_reset) rst_high <= rst_high + 1;
    if (cpu_reset && !cpu_halt) rst_run <= rst_run + 1;
    if (mem_raddr !== raddr_prev) raddr_changes <= raddr_changes + 1;
    raddr_prev <= mem_raddr;
  end

  logic [7:0] ref_mem [MSIZE];
  int tx_seen = 0;
  int wr_seen = 0;

  task automatic send_byte(input logic [7:0] b, output logic wr_now);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wr_now   = mem_write;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input int a, input int n);
    logic w;
    send_byte(op, w);
    send_byte(8'(a >> 8), w);
    send_byte(8'(a), w);
    send_byte(8'(n >> 8), w);
    send_byte(8'(n), w);
  endtask

  task automatic send_exec(input int a);
    logic w;
    send_byte(8'h58, w);
    send_byte(8'(a >> 8), w);
    send_byte(8'(a), w);
  endtask

  task automatic wait_tx(input int n, input int budget, output int got);
    int cyc = 0;
    while ((tx_q.size() - tx_seen) < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    got = tx_q.size() - tx_seen;
  endtask

  task automatic pop_tx(output logic [7:0] b);
    if (tx_seen < tx_q.size()) begin
      b = tx_q[tx_seen];
      tx_seen++;
    end else begin
      b = 'x;
    end
  endtask

  task automatic pop_wr(output logic [AW-1:0] a, output logic [7:0] d);
    if (wr_seen < wr_a_q.size()) begin
      a = wr_a_q[wr_seen];
      d = wr_d_q[wr_seen];
      wr_seen++;
    end else begin
      a = 'x;
      d = 'x;
    end
  endtask

  task automatic test_reset();
    ram_fill = 1'b1;
    for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
    repeat (2) @(negedge clk);
    ram_fill = 1'b0;
    compared++;
    if ({tx_start, mem_write, start_address} !== {2'b00, 9'h000}) begin
      mismatched++;
      $display("FAIL reset_outputs: got tx_start=%b mem_write=%b start=%h required 0 0 000",
               tx_start, mem_write, start_address);
    end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if ({cpu_reset, cpu_halt, mem_owner} !== 3'b111) begin
        mismatched++;
        $display("FAIL reset_ctrl: got reset/halt/owner=%b required 111",
                 {cpu_reset, cpu_halt, mem_owner});
      end
    end
    compared++;
    if (tx_q.size() !== 0) begin
      mismatched++;
      $display("FAIL reset_no_tx: got %0d tx bytes required 0", tx_q.size());
    end
    $display("reset: released, cpu held stopped");
  endtask

  task automatic test_load();
    logic [7:0] data [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic w;
    logic [AW-1:0] a;
    logic [7:0] d, r;
    int got;
    send_hdr(8'h4C, 16'h0010, 3);
    for (int i = 0; i < 3; i++) begin
      send_byte(data[i], w);
      compared++;
      if (w !== 1'b1) begin
        mismatched++;
        $display("FAIL load_write_timing: byte %0d mem_write=%b required 1 one cycle after rx", i, w);
      end
    end
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h31) begin
      mismatched++;
      $display("FAIL load_reply: got %h required 31", r);
    end
    compared++;
    if (wr_a_q.size() - wr_seen !== 3) begin
      mismatched++;
      $display("FAIL load_write_count: got %0d required 3", wr_a_q.size() - wr_seen);
    end
    for (int i = 0; i < 3; i++) begin
      pop_wr(a, d);
      compared++;
      if ({a, d} !== {9'(16 + i), data[i]}) begin
        mismatched++;
        $display("FAIL load_write: got %h=%h required %h=%h", a, d, 9'(16 + i), data[i]);
      end
      ref_mem[16 + i] = data[i];
    end
    $display("load: 4C 00 10 00 03 AA BB CC reply %h", r);
  endtask

  task automatic test_read_busy();
    int snap, got;
    logic [7:0] r;
    force_busy = 1'b1;
    send_hdr(8'h52, 16'h0010, 3);
    repeat (3) @(negedge clk);
    snap = raddr_changes;
    repeat (100) @(negedge clk);
    compared++;
    if (tx_q.size() - tx_seen !== 0) begin
      mismatched++;
      $display("FAIL read_hold_tx: got %0d bytes while busy required 0", tx_q.size() - tx_seen);
    end
    compared++;
    if (raddr_changes !== snap || mem_raddr !== 9'h010) begin
      mismatched++;
      $display("FAIL read_hold_addr: got raddr=%h changes=%0d required 010 changes=%0d",
               mem_raddr, raddr_changes, snap);
    end
    force_busy = 1'b0;
    wait_tx(3, 300, got);
    for (int i = 0; i < 3; i++) begin
      pop_tx(r);
      compared++;
      if (r !== ref_mem[16 + i]) begin
        mismatched++;
        $display("FAIL read_data: byte %0d got %h required %h", i, r, ref_mem[16 + i]);
      end
    end
    $display("read: 52 00 10 00 03 held busy 100 clks, got %0d bytes", got);
  endtask

  task automatic test_exec();
    int run0, snap, got;
    logic [7:0] r;
    run0 = rst_run;
    send_exec(16'h0020);
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h58) begin
      mismatched++;
      $display("FAIL exec_reply: got %h required 58", r);
    end
    compared++;
    if ({start_address, cpu_reset, cpu_halt, mem_owner} !== {9'h020, 3'b000}) begin
      mismatched++;
      $display("FAIL exec_state: got start=%h reset/halt/owner=%b required 020 000",
               start_address, {cpu_reset, cpu_halt, mem_owner});
    end
    compared++;
    if (rst_run - run0 !== 1) begin
      mismatched++;
      $display("FAIL exec_reset_pulse: got %0d clks of reset with halt low required 1", rst_run - run0);
    end
    cpu_halted = 1'b0;
    snap = raddr_changes;
    send_hdr(8'h52, 16'h0000, 1);
    wait_tx(1, 200, got);
    pop_tx(r);
    repeat (20) @(negedge clk);
    compared++;
    if (r !== 8'h21 || raddr_changes !== snap) begin
      mismatched++;
      $display("FAIL exec_read_busy: got reply %h read issues %0d required 21 and 0", r, raddr_changes - snap);
    end
    compared++;
    if (tx_q.size() - tx_seen !== 0) begin
      mismatched++;
      $display("FAIL exec_read_extra: got %0d extra bytes required 0", tx_q.size() - tx_seen);
    end
    $display("exec: 58 00 20 reply 58, then R while cpu owns memory");
  endtask

  task automatic test_halt();
    int got;
    logic [7:0] r;
    logic w;
    send_byte(8'h48, w);
    compared++;
    if (cpu_halt !== 1'b1) begin
      mismatched++;
      $display("FAIL halt_request: got cpu_halt=%b required 1", cpu_halt);
    end
    repeat (5) @(negedge clk);
    compared++;
    if (tx_q.size() - tx_seen !== 0 || mem_owner !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_early: got %0d bytes owner=%b required 0 bytes owner=0",
               tx_q.size() - tx_seen, mem_owner);
    end
    cpu_halted = 1'b1;
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h48 || mem_owner !== 1'b1) begin
      mismatched++;
      $display("FAIL halt_reply: got %h owner=%b required 48 owner=1", r, mem_owner);
    end
    $display("halt: 48 reply %h after cpu_halted", r);
  endtask

  task automatic test_exec_pulse();
    int high0, run0, got;
    logic [7:0] r;
    high0 = rst_high;
    run0  = rst_run;
    send_exec(16'h0140);
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h58 || start_address !== 9'h140) begin
      mismatched++;
      $display("FAIL exec2_reply: got %h start=%h required 58 140", r, start_address);
    end
    compared++;
    if (rst_high - high0 !== 1 || rst_run - run0 !== 1) begin
      mismatched++;
      $display("FAIL exec2_pulse: got reset clks %0d overlap %0d required 1 1",
               rst_high - high0, rst_run - run0);
    end
    cpu_halted = 1'b0;
    $display("exec: 58 01 40 reply %h, single reset clock", r);
  endtask

  task automatic test_reset_mid();
    logic w;
    send_byte(8'h52, w);
    send_byte(8'h00, w);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    compared++;
    if ({cpu_reset, cpu_halt, mem_owner} !== 3'b111) begin
      mismatched++;
      $display("FAIL reset_async: got reset/halt/owner=%b required 111 before any clock",
               {cpu_reset, cpu_halt, mem_owner});
    end
    cpu_halted = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    compared++;
    if (tx_q.size() - tx_seen !== 0) begin
      mismatched++;
      $display("FAIL reset_mid_reply: got %0d bytes required 0", tx_q.size() - tx_seen);
    end
    $display("reset: asserted mid-command, no reply");
  endtask

  task automatic test_wrap_timeout();
    logic w;
    logic [AW-1:0] a;
    logic [7:0] d, r;
    int got;
    send_hdr(8'h4C, 16'h01FF, 2);
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h33) begin
      mismatched++;
      $display("FAIL wrap_reply: got %h required 33", r);
    end
    pop_wr(a, d);
    compared++;
    if ({a, d} !== {9'h1FF, 8'h11}) begin
      mismatched++;
      $display("FAIL wrap_write0: got %h=%h required 1ff=11", a, d);
    end
    pop_wr(a, d);
    compared++;
    if ({a, d} !== {9'h000, 8'h22}) begin
      mismatched++;
      $display("FAIL wrap_write1: got %h=%h required 000=22", a, d);
    end
    ref_mem[511] = 8'h11;
    ref_mem[0]   = 8'h22;
    send_hdr(8'h4C, 16'h0050, 3);
    send_byte(8'h77, w);
    send_byte(8'h88, w);
    wait_tx(1, TMO + 20, got);
    compared++;
    if (got !== 0 || wr_a_q.size() - wr_seen !== 2) begin
      mismatched++;
      $display("FAIL partial_load: got %0d replies %0d writes required 0 and 2", got, wr_a_q.size() - wr_seen);
    end
    for (int i = 0; i < 2; i++) begin
      pop_wr(a, d);
      ref_mem[80 + i] = (i == 0) ? 8'h77 : 8'h88;
    end
    send_byte(8'h4C, w);
    send_byte(8'h00, w);
    send_byte(8'h00, w);
    wait_tx(1, TMO + 20, got);
    compared++;
    if (got !== 0) begin
      mismatched++;
      $display("FAIL timeout_silent: got %0d replies required 0", got);
    end
    send_byte(8'h5A, w);
    wait_tx(1, 200, got);
    pop_tx(r);
    compared++;
    if (r !== 8'h3F) begin
      mismatched++;
      $display("FAIL bad_opcode: got %h required 3f", r);
    end
    $display("wrap/timeout: 1FF->000 wrap, partial load kept, 5A reply %h", r);
  endtask

  task automatic test_random();
    logic w;
    logic [AW-1:0] a;
    logic [7:0] d, r, sum, op;
    logic [7:0] data [8];
    int addr, n, got, idx;
    for (int it = 0; it < 10; it++) begin
      busy_len = $urandom_range(0, 4);
      addr = $urandom_range(0, 65535);
      n    = $urandom_range(0, 6);
      sum  = 8'h00;
      send_hdr(8'h4C, addr, n);
      for (int i = 0; i < n; i++) begin
        data[i] = 8'($urandom);
        sum += data[i];
        send_byte(data[i], w);
      end
      wait_tx(1, 200, got);
      pop_tx(r);
      compared++;
      if (r !== sum || wr_a_q.size() - wr_seen !== n) begin
        mismatched++;
        $display("FAIL rand_load: addr %h n %0d got reply %h writes %0d required %h %0d",
                 addr, n, r, wr_a_q.size() - wr_seen, sum, n);
      end
      for (int i = 0; i < n; i++) begin
        idx = (addr + i) % MSIZE;
        pop_wr(a, d);
        compared++;
        if ({a, d} !== {9'(idx), data[i]}) begin
          mismatched++;
          $display("FAIL rand_write: got %h=%h required %h=%h", a, d, 9'(idx), data[i]);
        end
        ref_mem[idx] = data[i];
      end
      $display("rand load: addr %h n %0d reply %h", addr, n, r);

      addr = (it % 2 == 0) ? addr : $urandom_range(0, 65535);
      n    = $urandom_range(0, 5);
      send_hdr(8'h52, addr, n);
      wait_tx(n, 40 * n + 60, got);
      compared++;
      if (got !== n) begin
        mismatched++;
        $display("FAIL rand_read_count: addr %h got %0d bytes required %0d", addr, got, n);
      end
      for (int i = 0; i < n; i++) begin
        idx = (addr + i) % MSIZE;
        pop_tx(r);
        compared++;
        if (r !== ref_mem[idx]) begin
          mismatched++;
          $display("FAIL rand_read: addr %h got %h required %h", 9'(idx), r, ref_mem[idx]);
        end
      end
      $display("rand read: addr %h n %0d", addr, n);

      op = 8'($urandom);
      if (op == 8'h4C || op == 8'h52 || op == 8'h48 || op == 8'h58) op = 8'h00;
      send_byte(op, w);
      wait_tx(1, 200, got);
      pop_tx(r);
      compared++;
      if (r !== 8'h3F) begin
        mismatched++;
        $display("FAIL rand_bad_opcode: op %h got %h required 3f", op, r);
      end
      $display("rand opcode: %h reply %h", op, r);
    end
    repeat (20) @(negedge clk);
    compared++;
    if (tx_while_busy !== 0) begin
      mismatched++;
      $display("FAIL tx_protocol: got %0d starts while busy required 0", tx_while_busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_busy();
    test_exec();
    test_halt();
    test_exec_pulse();
    test_reset_mid();
    test_wrap_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
